robot_plant_resp: RTL and testbench



---
 rtl/robot_plant_pkg.sv | 27 ++
 rtl/robot_plant_resp_pulse_timer.sv | 54 +++++
 rtl/robot_plant_resp.sv | 208 ++++++++++++++++++++
 tb/tb_robot_plant_resp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_plant_pkg.sv
// Shared constants for the robotben plant responder: actuator command bit
// positions and the start-request state encoding.
package robot_plant_pkg;

    localparam int CMD_W         = 43;
    localparam int CMD_MOVE      = 33;
    localparam int CMD_GRIP      = 11;
    localparam int CMD_CLAMP     = 27;
    localparam int CMD_START_ACK = 12;
    localparam int CMD_HOME_A    = 1;
    localparam int CMD_HOME_B    = 4;
    localparam int CMD_UNLOAD    = 21;
    localparam int CMD_RELEASE   = 15;
    localparam int CMD_PRESS     = 31;

    typedef enum logic [1:0] {
        S_GAP = 2'd0,
        S_REQ = 2'd1,
        S_RUN = 2'd2
    } start_state_t;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/robot_plant_resp_pulse_timer.sv
// One-shot delayed pulse: a trigger seen while idle produces a HOLD-cycle
// high pulse starting LAT+1 cycles later; triggers while busy are dropped.
module plant_pulse_timer
    import robot_plant_pkg::*;
#(
    parameter int LAT  = 2,
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic out
);

    localparam int          SPAN   = LAT + HOLD + 1;
    localparam int          TW     = cnt_width(SPAN);
    localparam logic [TW-1:0] SPAN_V = TW'(SPAN);
    localparam logic [TW-1:0] HOLD_V = TW'(HOLD);

    generate
        if (LAT < 1 || HOLD < 1) begin : g_bad_param
            $error("plant_pulse_timer: LAT and HOLD must be nonzero");
        end
    endgenerate

    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_next;
    logic          r_out;

    // The count runs SPAN..1; the last HOLD counts form the output window.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_cnt == '0) begin
            if (trig) begin
                w_cnt_next = SPAN_V;
            end
        end else begin
            w_cnt_next = r_cnt - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_out <= (w_cnt_next != '0) && (w_cnt_next <= HOLD_V);
        end
    end

    assign out = r_out;

endmodule

// File: rtl/robot_plant_resp.sv
// Closed-loop plant model for the robotben controller: turns actuator
// commands into timed sensor responses, counts work cycles, flags conflicts.
module robot_plant_resp
    import robot_plant_pkg::*;
#(
    parameter int MOVE_LAT    = 3,
    parameter int GRIP_LAT    = 2,
    parameter int GRIP_HOLD   = 4,
    parameter int CLAMP_LAT   = 2,
    parameter int CLAMP_HOLD  = 3,
    parameter int START_GAP   = 8,
    parameter int PART_PERIOD = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] cmd,
    output logic             x1,
    output logic             x2,
    output logic             x3,
    output logic             x4,
    output logic             x5,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int MW = cnt_width(MOVE_LAT);
    localparam int GW = cnt_width(START_GAP);
    localparam int PW = (PART_PERIOD > 1) ? $clog2(PART_PERIOD) : 1;

    localparam logic [MW-1:0] MOVE_V    = MW'(MOVE_LAT);
    localparam logic [GW-1:0] GAP_V     = GW'(START_GAP);
    localparam logic [PW-1:0] PART_LAST = PW'(PART_PERIOD - 1);

    generate
        if (MOVE_LAT < 1 || GRIP_LAT < 1 || GRIP_HOLD < 1 || CLAMP_LAT < 1 ||
            CLAMP_HOLD < 1 || START_GAP < 1 || PART_PERIOD < 1 || CNT_W < 1) begin : g_bad_param
            $error("robot_plant_resp: all parameters must be nonzero");
        end
    endgenerate

    // Motion channel: retriggerable countdown, x1 latches high at expiry.
    logic [MW-1:0] r_move_tmr;
    logic [MW-1:0] w_move_tmr_next;
    logic          r_x1;
    logic          w_x1_next;

    always_comb begin
        w_move_tmr_next = r_move_tmr;
        w_x1_next       = r_x1;
        if (cmd[CMD_MOVE]) begin
            w_move_tmr_next = MOVE_V;
            w_x1_next       = 1'b0;
        end else if (r_move_tmr != '0) begin
            w_move_tmr_next = r_move_tmr - MW'(1);
            if (r_move_tmr == MW'(1)) begin
                w_x1_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_move_tmr <= '0;
            r_x1       <= 1'b0;
        end else begin
            r_move_tmr <= w_move_tmr_next;
            r_x1       <= w_x1_next;
        end
    end

    // Gripper and clamp share the same delayed-pulse behaviour.
    logic w_x3;
    logic w_x2;

    plant_pulse_timer #(
        .LAT  (GRIP_LAT),
        .HOLD (GRIP_HOLD)
    ) u_grip (
        .clk  (clk),
        .rst  (rst),
        .trig (cmd[CMD_GRIP]),
        .out  (w_x3)
    );

    plant_pulse_timer #(
        .LAT  (CLAMP_LAT),
        .HOLD (CLAMP_HOLD)
    ) u_clamp (
        .clk  (clk),
        .rst  (rst),
        .trig (cmd[CMD_CLAMP]),
        .out  (w_x2)
    );

    // Start FSM with work-cycle bookkeeping.
    start_state_t     r_state;
    start_state_t     w_state_next;
    logic [GW-1:0]    r_gap;
    logic [GW-1:0]    w_gap_next;
    logic             r_x4;
    logic             w_x4_next;
    logic             r_busy;
    logic             w_busy_next;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] w_cycle_cnt_next;
    logic [PW-1:0]    r_part;
    logic [PW-1:0]    w_part_next;
    logic             r_x5;
    logic             w_x5_next;
    logic             w_cycle_end;

    assign w_cycle_end = (cmd[CMD_HOME_A] & cmd[CMD_HOME_B]) | cmd[CMD_UNLOAD];

    always_comb begin
        w_state_next     = r_state;
        w_gap_next       = r_gap;
        w_x4_next        = r_x4;
        w_busy_next      = r_busy;
        w_cycle_cnt_next = r_cycle_cnt;
        w_part_next      = r_part;
        w_x5_next        = r_x5;
        case (r_state)
            S_GAP: begin
                if (r_gap == '0) begin
                    w_state_next = S_REQ;
                    w_x4_next    = 1'b1;
                end else begin
                    w_gap_next = r_gap - GW'(1);
                end
            end
            S_REQ: begin
                if (cmd[CMD_START_ACK]) begin
                    w_state_next = S_RUN;
                    w_x4_next    = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_cycle_end) begin
                    w_state_next = S_GAP;
                    w_busy_next  = 1'b0;
                    w_gap_next   = GAP_V;
                    if (r_cycle_cnt != '1) begin
                        w_cycle_cnt_next = r_cycle_cnt + CNT_W'(1);
                    end
                    // Absence is decided by the part index of the cycle just finished.
                    w_x5_next   = (r_part != PART_LAST);
                    w_part_next = (r_part == PART_LAST) ? '0 : r_part + PW'(1);
                end
            end
            default: begin
                w_state_next = S_GAP;
                w_gap_next   = GAP_V;
                w_x4_next    = 1'b0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_GAP;
            r_gap       <= GAP_V;
            r_x4        <= 1'b0;
            r_busy      <= 1'b0;
            r_cycle_cnt <= '0;
            r_part      <= '0;
            r_x5        <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_gap       <= w_gap_next;
            r_x4        <= w_x4_next;
            r_busy      <= w_busy_next;
            r_cycle_cnt <= w_cycle_cnt_next;
            r_part      <= w_part_next;
            r_x5        <= w_x5_next;
        end
    end

    // Sticky conflict flag: grip+clamp or release+press in one cycle.
    logic r_err;
    logic w_illegal;

    assign w_illegal = (cmd[CMD_GRIP] & cmd[CMD_CLAMP]) | (cmd[CMD_RELEASE] & cmd[CMD_PRESS]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_illegal;
        end
    end

    logic w_unused_cmd;
    assign w_unused_cmd = ^cmd;

    assign x1        = r_x1;
    assign x2        = w_x2;
    assign x3        = w_x3;
    assign x4        = r_x4;
    assign x5        = r_x5;
    assign busy      = r_busy;
    assign err       = r_err;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_robot_plant_resp.sv
// Bench for robot_plant_resp: directed scenarios plus random commands, every
// cycle compared with an edge-timestamp reference model.
module tb_robot_plant_resp;
    import robot_plant_pkg::*;

    localparam int ML = 3;
    localparam int GL = 2;
    localparam int GH = 4;
    localparam int CL = 2;
    localparam int CH = 3;
    localparam int SG = 8;
    localparam int PP = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [42:0]   cmd = '0;
    logic          x1, x2, x3, x4, x5, busy, err;
    logic [CW-1:0] cycle_cnt;

    always #5 clk = ~clk;

    robot_plant_resp #(
        .MOVE_LAT    (ML),
        .GRIP_LAT    (GL),
        .GRIP_HOLD   (GH),
        .CLAMP_LAT   (CL),
        .CLAMP_HOLD  (CH),
        .START_GAP   (SG),
        .PART_PERIOD (PP),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .x5        (x5),
        .busy      (busy),
        .err       (err),
        .cycle_cnt (cycle_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Reference model: remembers when things happened, derives outputs by
    // elapsed-edge arithmetic. mode: 0 waiting gap, 1 requesting, 2 working.
    longint edge_n   = 0;
    int     m_mode   = 0;
    longint gap_edge = 0;
    int     ends     = 0;
    bit     mv_seen  = 0;
    longint mv_edge  = 0;
    bit     gr_seen  = 0;
    longint gr_edge  = 0;
    bit     cl_seen  = 0;
    longint cl_edge  = 0;
    bit     m_err    = 0;

    task automatic model_step(input logic r, input logic [42:0] c);
        edge_n++;
        if (r) begin
            m_mode   = 0;
            gap_edge = edge_n;
            ends     = 0;
            mv_seen  = 0;
            gr_seen  = 0;
            cl_seen  = 0;
            m_err    = 0;
            return;
        end
        if ((c[CMD_GRIP] && c[CMD_CLAMP]) || (c[CMD_RELEASE] && c[CMD_PRESS])) m_err = 1;
        if (c[CMD_MOVE]) begin
            mv_seen = 1;
            mv_edge = edge_n;
        end
        if (c[CMD_GRIP] && (!gr_seen || edge_n >= gr_edge + GL + GH + 2)) begin
            gr_seen = 1;
            gr_edge = edge_n;
        end
        if (c[CMD_CLAMP] && (!cl_seen || edge_n >= cl_edge + CL + CH + 2)) begin
            cl_seen = 1;
            cl_edge = edge_n;
        end
        case (m_mode)
            0: if (edge_n == gap_edge + SG + 1) m_mode = 1;
            1: if (c[CMD_START_ACK]) m_mode = 2;
            default: begin
                if ((c[CMD_HOME_A] && c[CMD_HOME_B]) || c[CMD_UNLOAD]) begin
                    ends++;
                    m_mode   = 0;
                    gap_edge = edge_n;
                end
            end
        endcase
    endtask

    task automatic check_all();
        bit e_x1, e_x2, e_x3, e_x5;
        int e_cnt;
        e_x1  = mv_seen && (edge_n - mv_edge >= ML);
        e_x3  = gr_seen && (edge_n - gr_edge >= GL + 1) && (edge_n - gr_edge <= GL + GH);
        e_x2  = cl_seen && (edge_n - cl_edge >= CL + 1) && (edge_n - cl_edge <= CL + CH);
        e_x5  = !(ends > 0 && (ends % PP) == 0);
        e_cnt = (ends > 255) ? 255 : ends;
        check_val("x1", x1, e_x1);
        check_val("x2", x2, e_x2);
        check_val("x3", x3, e_x3);
        check_val("x4", x4, m_mode == 1);
        check_val("x5", x5, e_x5);
        check_val("busy", busy, m_mode == 2);
        check_val("err", err, m_err);
        check_val("cycle_cnt", cycle_cnt, e_cnt);
    endtask

    task automatic tick(input logic r, input logic [42:0] c);
        rst = r;
        cmd = c;
        @(posedge clk);
        model_step(r, c);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, '0);
    endtask

    function automatic logic [42:0] bit_of(input int i);
        logic [42:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    localparam int RND_IDX [9] = '{CMD_MOVE, CMD_GRIP, CMD_CLAMP, CMD_START_ACK,
                                   CMD_HOME_A, CMD_HOME_B, CMD_UNLOAD, CMD_RELEASE, CMD_PRESS};

    initial begin
        logic [63:0] rw;
        logic [42:0] rc;
        bit          exp_x5 [5];
        exp_x5 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset and idle start request
        repeat (3) tick(1'b1, '0);
        check_val("rst_x5", x5, 1);
        check_val("rst_x4", x4, 0);
        check_val("rst_cnt", cycle_cnt, 0);
        idle(8);
        check_val("gap8_x4", x4, 0);
        idle(1);
        check_val("gap9_x4", x4, 1);
        idle(3);
        check_val("req_hold_x4", x4, 1);
        $display("[TB] start request seen after gap");

        tick(1'b0, bit_of(CMD_START_ACK));
        check_val("ack_x4", x4, 0);
        check_val("ack_busy", busy, 1);

        // Move latency
        tick(1'b0, bit_of(CMD_MOVE));
        check_val("move_t1", x1, 0);
        idle(2);
        check_val("move_t3", x1, 0);
        idle(1);
        check_val("move_t4", x1, 1);
        idle(2);
        check_val("move_hold", x1, 1);
        $display("[TB] move pulse done");

        // Move retrigger
        tick(1'b0, bit_of(CMD_MOVE));
        idle(1);
        tick(1'b0, bit_of(CMD_MOVE));
        idle(1);
        check_val("retrig_t3", x1, 0);
        idle(1);
        check_val("retrig_t4", x1, 0);
        idle(1);
        check_val("retrig_t5", x1, 1);
        $display("[TB] move retrigger done");

        // Gripper pulse with ignored re-trigger
        tick(1'b0, bit_of(CMD_GRIP));
        idle(2);
        check_val("grip_t2", x3, 0);
        idle(1);
        check_val("grip_t3", x3, 1);
        tick(1'b0, bit_of(CMD_GRIP));
        idle(2);
        check_val("grip_t6", x3, 1);
        idle(1);
        check_val("grip_t7", x3, 0);
        idle(3);
        check_val("grip_t10", x3, 0);
        $display("[TB] grip pulse done");

        // Work cycles and part pattern
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                idle(10);
                tick(1'b0, bit_of(CMD_START_ACK));
                tick(1'b0, bit_of(CMD_HOME_A));
                check_val("half_home_busy", busy, 1);
            end
            tick(1'b0, (i % 2 == 1) ? (bit_of(CMD_HOME_A) | bit_of(CMD_HOME_B)) : bit_of(CMD_UNLOAD));
            check_val("end_x5", x5, exp_x5[i]);
            check_val("end_cnt", cycle_cnt, i + 1);
            check_val("end_busy", busy, 0);
            $display("[TB] work cycle %0d ended: x5=%0b cycle_cnt=%0d", i + 1, x5, cycle_cnt);
        end

        // Illegal combination then reset mid-pulse
        tick(1'b0, bit_of(CMD_GRIP) | bit_of(CMD_CLAMP));
        check_val("err_set", err, 1);
        idle(3);
        check_val("err_sticky", err, 1);
        check_val("err_x3", x3, 1);
        check_val("err_x2", x2, 1);
        tick(1'b1, '0);
        check_val("midrst_x2", x2, 0);
        check_val("midrst_x3", x3, 0);
        check_val("midrst_x1", x1, 0);
        check_val("midrst_x5", x5, 1);
        check_val("midrst_err", err, 0);
        check_val("midrst_cnt", cycle_cnt, 0);
        $display("[TB] illegal command and mid-pulse reset done");

        // Counter saturation
        for (int i = 0; i < 258; i++) begin
            idle(9);
            tick(1'b0, bit_of(CMD_START_ACK));
            tick(1'b0, bit_of(CMD_UNLOAD));
        end
        check_val("sat_cnt", cycle_cnt, 255);
        $display("[TB] saturation run done: cycle_cnt=%0d", cycle_cnt);

        // Random commands with occasional reset
        for (int i = 0; i < 4000; i++) begin
            rw = {$urandom(), $urandom()};
            rc = rw[42:0];
            foreach (RND_IDX[k]) rc[RND_IDX[k]] = ($urandom_range(0, 5) == 0);
            tick($urandom_range(0, 199) == 0, rc);
        end
        $display("[TB] random phase done: %0d work cycles since last reset", ends);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
